// File: rtl/billiard_pkg.sv
// Shared types and sizing helpers for the billiard game blocks.
package billiard_pkg;

    localparam int POWER_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AIM,
        S_CHARGE,
        S_STRIKE,
        S_ROLL,
        S_DONE
    } shot_state_t;

    // Bits needed to hold 0..terminal, never less than one.
    function automatic int cnt_width(input int terminal);
        return (terminal < 1) ? 1 : $clog2(terminal + 1);
    endfunction

endpackage

// File: rtl/shot_controller_frame_counter.sv
// Frame-rate event counter: counts enable pulses 0..TERMINAL and wraps,
// flagging the pulse that lands on TERMINAL.
module frame_counter
    import billiard_pkg::*;
#(
    parameter int TERMINAL = 3
) (
    input  logic clk,
    input  logic resetN,
    input  logic en,
    input  logic clr,
    output logic done
);

    localparam int W = cnt_width(TERMINAL);
    localparam logic [W-1:0] LAST = W'(TERMINAL);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    // Combinational so the owner can act on the same cycle as the final pulse.
    assign done = en && !clr && (count == LAST);

endmodule

// File: rtl/shot_controller.sv
// Cue shot sequencer: aim, ping-pong power charge while Enter is held,
// one-cycle strike, then wait for the table to settle or time out.
module shot_controller
    import billiard_pkg::*;
#(
    parameter int MAX_POWER      = 15,
    parameter int CHARGE_TICKS   = 4,
    parameter int SETTLE_FRAMES  = 8,
    parameter int TIMEOUT_FRAMES = 600
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               enterPressed,
    input  logic               shotEnable,
    input  logic               whiteBallStopped,
    input  logic               redBallStopped,
    input  logic               whiteBallShow,
    input  logic               redBallShow,
    output logic [POWER_W-1:0] power,
    output logic               strike,
    output logic [POWER_W-1:0] strikePower,
    output logic               drawLine,
    output logic               turnDone,
    output logic               forcedEnd,
    output logic               busy
);

    localparam logic [POWER_W-1:0] PMAX = POWER_W'(MAX_POWER);
    localparam logic [POWER_W-1:0] PMIN = POWER_W'(1);

    shot_state_t state, nxt;
    logic        enter_q;
    logic        dir_up;
    logic        settled;
    logic        tick_done, settle_done, timeout_done;
    logic        tick_clr, settle_en, settle_clr, roll_clr;

    // Returns {dir_up, power}; endpoints flip direction and step off immediately.
    function automatic logic [POWER_W:0] next_power(input logic [POWER_W-1:0] p,
                                                    input logic up);
        if (MAX_POWER <= 1)
            return {1'b1, p};
        if (up)
            return (p >= PMAX) ? {1'b0, p - 1'b1} : {1'b1, p + 1'b1};
        return (p <= PMIN) ? {1'b1, p + 1'b1} : {1'b0, p - 1'b1};
    endfunction

    // A hidden ball counts as settled regardless of its velocity flag.
    assign settled = (whiteBallStopped || !whiteBallShow) &&
                     (redBallStopped   || !redBallShow);

    assign tick_clr   = (state != S_CHARGE);
    assign roll_clr   = (state != S_ROLL);
    assign settle_en  = startOfFrame && settled;
    assign settle_clr = roll_clr || !settled;

    frame_counter #(.TERMINAL(CHARGE_TICKS - 1)) u_tick (
        .clk    (clk),
        .resetN (resetN),
        .en     (startOfFrame),
        .clr    (tick_clr),
        .done   (tick_done)
    );

    frame_counter #(.TERMINAL(SETTLE_FRAMES - 1)) u_settle (
        .clk    (clk),
        .resetN (resetN),
        .en     (settle_en),
        .clr    (settle_clr),
        .done   (settle_done)
    );

    frame_counter #(.TERMINAL(TIMEOUT_FRAMES - 1)) u_timeout (
        .clk    (clk),
        .resetN (resetN),
        .en     (startOfFrame),
        .clr    (roll_clr),
        .done   (timeout_done)
    );

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (shotEnable && settled) nxt = S_AIM;
            S_AIM: begin
                if (!shotEnable)                      nxt = S_IDLE;
                else if (enterPressed && !enter_q)    nxt = S_CHARGE;
            end
            S_CHARGE: begin
                if (!shotEnable)        nxt = S_IDLE;
                else if (!enterPressed) nxt = S_STRIKE;
            end
            S_STRIKE: nxt = S_ROLL;
            S_ROLL:   if (settle_done || timeout_done) nxt = S_DONE;
            S_DONE:   nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state       <= S_IDLE;
            enter_q     <= 1'b0;
            dir_up      <= 1'b0;
            power       <= '0;
            strikePower <= '0;
            strike      <= 1'b0;
            drawLine    <= 1'b0;
            turnDone    <= 1'b0;
            forcedEnd   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state     <= nxt;
            enter_q   <= enterPressed;
            strike    <= (nxt == S_STRIKE);
            drawLine  <= (nxt == S_AIM) || (nxt == S_CHARGE);
            turnDone  <= (nxt == S_DONE);
            forcedEnd <= (nxt == S_DONE) && timeout_done && !settle_done;
            busy      <= (nxt == S_CHARGE) || (nxt == S_STRIKE) ||
                         (nxt == S_ROLL)   || (nxt == S_DONE);

            if (state == S_AIM && nxt == S_CHARGE) begin
                power  <= PMIN;
                dir_up <= 1'b1;
            end else if (state == S_CHARGE && nxt == S_CHARGE) begin
                if (tick_done)
                    {dir_up, power} <= next_power(power, dir_up);
            end else if (state == S_CHARGE && nxt == S_STRIKE) begin
                strikePower <= power;
            end else begin
                power <= '0;
            end
        end
    end

endmodule

// File: tb/tb_shot_controller.sv
// Self-checking bench for shot_controller: frame-count based reference model
// compared every cycle, plus hand-computed spot checks.
module tb_shot_controller;

    localparam int MAXP = 15;
    localparam int CT   = 4;
    localparam int SETF = 8;
    localparam int TOF  = 600;

    localparam int PH_WAIT = 0, PH_AIM = 1, PH_CHARGE = 2, PH_FIRE = 3, PH_ROLL = 4, PH_END = 5;

    logic       clk = 1'b0;
    logic       resetN, startOfFrame, enterPressed, shotEnable;
    logic       whiteBallStopped, redBallStopped, whiteBallShow, redBallShow;
    logic [3:0] power, strikePower;
    logic       strike, drawLine, turnDone, forcedEnd, busy;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_en = 1'b0;

    // Reference model state
    int ph = PH_WAIT;
    int m_frames = 0;
    int m_sp = 0;
    int m_run = 0;
    int m_roll = 0;
    bit m_forced = 1'b0;
    bit m_prev_enter = 1'b0;

    shot_controller #(
        .MAX_POWER(MAXP), .CHARGE_TICKS(CT), .SETTLE_FRAMES(SETF), .TIMEOUT_FRAMES(TOF)
    ) dut (
        .clk              (clk),
        .resetN           (resetN),
        .startOfFrame     (startOfFrame),
        .enterPressed     (enterPressed),
        .shotEnable       (shotEnable),
        .whiteBallStopped (whiteBallStopped),
        .redBallStopped   (redBallStopped),
        .whiteBallShow    (whiteBallShow),
        .redBallShow      (redBallShow),
        .power            (power),
        .strike           (strike),
        .strikePower      (strikePower),
        .drawLine         (drawLine),
        .turnDone         (turnDone),
        .forcedEnd        (forcedEnd),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // Power after a number of charged frames, from the triangle-wave rule.
    function automatic int power_of(input int frames);
        int steps, period, p;
        if (MAXP <= 1) return 1;
        steps  = frames / CT;
        period = 2 * (MAXP - 1);
        p      = steps % period;
        return (p <= MAXP - 1) ? 1 + p : 1 + period - p;
    endfunction

    function automatic logic [12:0] expected();
        int pw;
        pw = (ph == PH_CHARGE) ? power_of(m_frames) : (ph == PH_FIRE) ? m_sp : 0;
        return {4'(pw), (ph == PH_FIRE), 4'(m_sp), (ph == PH_AIM || ph == PH_CHARGE),
                (ph == PH_END), (ph == PH_END && m_forced),
                (ph == PH_CHARGE || ph == PH_FIRE || ph == PH_ROLL || ph == PH_END)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model advance at each active edge from the inputs the DUT samples.
    initial forever begin
        bit settled;
        @(posedge clk);
        settled = (whiteBallStopped || !whiteBallShow) && (redBallStopped || !redBallShow);
        if (!resetN) begin
            ph = PH_WAIT; m_frames = 0; m_sp = 0; m_run = 0; m_roll = 0;
            m_forced = 1'b0; m_prev_enter = 1'b0;
        end else begin
            case (ph)
                PH_WAIT: if (shotEnable && settled) ph = PH_AIM;
                PH_AIM: begin
                    if (!shotEnable) ph = PH_WAIT;
                    else if (enterPressed && !m_prev_enter) begin
                        ph = PH_CHARGE; m_frames = 0;
                    end
                end
                PH_CHARGE: begin
                    if (!shotEnable) ph = PH_WAIT;
                    else if (!enterPressed) begin
                        ph = PH_FIRE; m_sp = power_of(m_frames);
                    end else if (startOfFrame) m_frames++;
                end
                PH_FIRE: begin
                    ph = PH_ROLL; m_run = 0; m_roll = 0;
                end
                PH_ROLL: begin
                    if (startOfFrame) begin
                        m_roll++;
                        m_run = settled ? m_run + 1 : 0;
                    end else if (!settled) m_run = 0;
                    if (m_run == SETF) begin
                        ph = PH_END; m_forced = 1'b0;
                    end else if (m_roll == TOF) begin
                        ph = PH_END; m_forced = 1'b1;
                    end
                end
                default: ph = PH_WAIT;
            endcase
            if (ph == PH_END && !(m_run == SETF || m_roll == TOF)) ph = PH_WAIT;
            m_prev_enter = enterPressed;
        end
    end

    // Per-cycle comparison on the falling edge.
    initial forever begin
        @(negedge clk);
        if (chk_en)
            chk("cycle_outputs",
                {19'd0, power, strike, strikePower, drawLine, turnDone, forcedEnd, busy},
                {19'd0, expected()});
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            startOfFrame = 1'b1; cyc();
            startOfFrame = 1'b0; cyc();
        end
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; enterPressed = 1'b0; shotEnable = 1'b0;
        whiteBallStopped = 1'b1; redBallStopped = 1'b1;
        whiteBallShow = 1'b1; redBallShow = 1'b1;
        cyc(2);
        chk_en = 1'b1;
        chk("reset_power", power, 0);
        chk("reset_busy_line", {busy, drawLine, strike, turnDone}, 0);

        // Charge ping-pong and release
        resetN = 1'b1; shotEnable = 1'b1;
        cyc();
        chk("aim_drawline", drawLine, 1);
        enterPressed = 1'b1; cyc();
        chk("charge_start_power", power, 1);
        frames(56);
        chk("power_at_56", power, 15);
        frames(3);
        chk("power_at_59", power, 15);
        frames(13);
        chk("power_at_72", power, 11);
        chk("no_strike_while_held", strike, 0);
        enterPressed = 1'b0; cyc();
        chk("strike_pulse", {strike, drawLine}, 2'b10);
        chk("strike_power", strikePower, 11);
        cyc();
        chk("strike_one_cycle", {strike, power, busy}, 6'b0_0000_1);

        // Settle interrupted by a moving white ball
        frames(5);
        whiteBallStopped = 1'b0; frames(1);
        whiteBallStopped = 1'b1; frames(7);
        chk("no_done_before_8th", turnDone, 0);
        startOfFrame = 1'b1; cyc();
        chk("turn_done_normal", {turnDone, forcedEnd}, 2'b10);
        startOfFrame = 1'b0; cyc();
        chk("turn_done_once", {turnDone, busy}, 2'b00);
        cyc();

        // Abort charge with shotEnable
        enterPressed = 1'b1; cyc();
        frames(16);
        chk("power_5", power, 5);
        shotEnable = 1'b0; cyc();
        chk("abort_outputs", {power, drawLine, strike, busy}, 0);
        cyc(2);
        enterPressed = 1'b0;
        chk("abort_keeps_strike_power", strikePower, 11);

        // Timeout with red ball rolling forever
        shotEnable = 1'b1; cyc();
        enterPressed = 1'b1; cyc();
        frames(4);
        enterPressed = 1'b0; cyc();
        chk("strike_power_2", strikePower, 2);
        redBallStopped = 1'b0; cyc();
        frames(599);
        chk("no_timeout_at_599", turnDone, 0);
        startOfFrame = 1'b1; cyc();
        chk("timeout_done", {turnDone, forcedEnd}, 2'b11);
        startOfFrame = 1'b0; redBallStopped = 1'b1; cyc();
        chk("timeout_pulse_clears", {turnDone, forcedEnd}, 2'b00);
        cyc();

        // Pocketed white ball, then Enter held across aim entry
        whiteBallShow = 1'b0; whiteBallStopped = 1'b0;
        enterPressed = 1'b1; cyc();
        frames(4);
        enterPressed = 1'b0; cyc(2);
        frames(7);
        startOfFrame = 1'b1; cyc();
        chk("pocketed_done", {turnDone, forcedEnd}, 2'b10);
        startOfFrame = 1'b0; enterPressed = 1'b1;
        cyc(4);
        chk("held_enter_no_charge", {drawLine, busy, power}, 6'b10_0000);
        enterPressed = 1'b0; cyc();
        enterPressed = 1'b1; cyc();
        chk("repress_charges", {busy, power}, 5'b1_0001);

        // Reset in the middle of rolling
        enterPressed = 1'b0; cyc(2);
        frames(3);
        chk("rolling_busy", busy, 1);
        resetN = 1'b0; cyc();
        chk("reset_mid_roll", {power, strikePower, strike, drawLine, turnDone, forcedEnd, busy}, 0);
        resetN = 1'b1; cyc(3);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
